shared_reg_arbiter: RTL and testbench
=====================================

Name: shared_reg_arbiter

Overview:
- Round-robin write arbiter that shares one W-bit state register, e.g. a reg2-style flop, between N requesters.
- Requesters raise REQ with write data; the arbiter grants one at a time and performs the register update.
- LOCK lets a requester keep the grant for a bounded burst of back-to-back writes.
- Sits between requester logic and the shared register. Also serves as a sequential test vehicle for the toolbox metrics/analysis flows: FSM, counters, nested if/case.

Parameters:
- N, 4, number of requesters (2..8).
- W, 8, width of the shared register and of each requester's data.
- MAX_BURST, 4, maximum consecutive writes per grant under LOCK (1..15).
- RST_VAL, 0, reset value of the shared register.

Ports:
- CLK  input  1  sole clock; all state on rising edge.
- RST  input  1  synchronous reset, active-low.
- REQ  input  N  per-requester write request; level, held until granted.
- LOCK  input  N  per-requester burst hold; sampled only for the granted requester.
- DATA  input  N*W  write data; requester i occupies bits [i*W +: W].
- GNT  output  N  one-hot grant, registered.
- REG_OUT  output  W  shared register value.
- REG_VALID  output  1  one-cycle pulse the cycle after REG_OUT changed by a write.
- WR_SRC  output  $clog2(N)  index of the requester that produced the last write.
- BUSY  output  1  high whenever state != IDLE.

Behaviour:
- Reset: RST==0 at a rising edge gives state=IDLE, GNT=0, REG_OUT=RST_VAL, REG_VALID=0, WR_SRC=0, pointer=0, burst count=0. Reset mid-burst aborts the burst with no write on that edge.
- States are IDLE and GRANT.
- IDLE:
  - If REQ!=0 at an edge: select the first set REQ bit searching from pointer upward with wrap-around (pointer, pointer+1, ..., N-1, 0, ...).
  - Registered result: GNT[g]=1, state=GRANT, burst count=0.
  - REQ==0: remain in IDLE.
- GRANT, write rule: at each edge with REQ[g]=1, REG_OUT <= DATA[g], WR_SRC <= g, and REG_VALID=1 in the next cycle. Latency from REQ rise (IDLE) to first REG_OUT update is 2 edges.
- GRANT, continue: if LOCK[g]=1, REQ[g]=1 and burst count < MAX_BURST-1, stay in GRANT, increment burst count, keep GNT.
- GRANT, release (any other case):
  - Includes REQ[g]=0, which releases with no write.
  - GNT=0, pointer <= (g+1) mod N, state=IDLE.
  - One idle cycle is mandatory between grants; a requester never sees GNT for two grants back-to-back.
- MAX_BURST=1: LOCK has no effect.
- Simultaneous events:
  - REQ from other requesters during GRANT is ignored until the next IDLE.
  - LOCK from a non-granted requester is ignored.
  - LOCK dropping on the same edge as a write still performs that write, then releases.
- Pointer update:
  - The pointer advances only on release, including abandoned grants, so starvation is impossible.
  - Worst-case wait for requester i is (N-1)*(MAX_BURST+1) cycles.
- Invariants:
  - GNT is always one-hot or zero.
  - REG_OUT changes only on edges where GNT[g] & REQ[g].
  - REG_VALID is never high in the cycle after reset.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=1'b0, GRANT=1'b1.
  - RST_VAL default.
  - A clog2 helper function for the WR_SRC and pointer widths.
- One sub-module, rr_pick: combinational, inputs REQ[N] and pointer, outputs one-hot select and index plus an any-request flag. The FSM, burst counter and data register stay in the top.

Test Plan:
- Reset: hold RST=0 for 2 cycles with REQ=4'b1111 -> GNT=0, REG_OUT=0, BUSY=0. Release RST -> GNT=4'b0001 after 1 edge, REG_OUT=DATA[0] after 2 edges, REG_VALID pulse.
- Round robin: REQ=4'b1111 held, LOCK=0, DATA[i]=8'h10+i -> GNT sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001. REG_OUT takes the values 10,11,12,13,10 in turn.
- Burst cap: REQ[2]=1 and LOCK[2]=1 held, MAX_BURST=4, DATA[2] incrementing each cycle from 8'hA0 -> exactly 4 writes (A0..A3 sampled), GNT[2] high for 4 cycles, then 1 idle cycle, then re-grant to 2.
- Abandon: grant to 1, then REQ[1]=0 on the next edge -> no write, REG_VALID stays 0, pointer=2; with REQ=4'b0011, next grant goes to 0.
- Reset mid-burst: RST=0 while GNT[3] is held under LOCK -> on that edge REG_OUT=RST_VAL, GNT=0, pointer=0, and no REG_VALID pulse.
- Ignored inputs: during GRANT to 0, toggle LOCK[1] and REQ[2] -> GNT stays one-hot on 0, and the grant releases per LOCK[0] only.

Source files
------------

// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and helpers for the round-robin shared-register write arbiter.
package shared_reg_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int DEFAULT_RST_VAL = 0;

  // Index width for N requesters; never below 1 so N=2 still gets a real bit.
  function automatic int idxWidth(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Requester-side bus of the shared-register arbiter: requests, burst locks,
// write data in, grant and shared register state out.
interface shared_reg_arbiter_if
  import shared_reg_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
);

  localparam int IW = idxWidth(N);

  logic [N-1:0]   req;
  logic [N-1:0]   lock;
  logic [N*W-1:0] data;
  logic [N-1:0]   gnt;
  logic [W-1:0]   regOut;
  logic           regValid;
  logic [IW-1:0]  wrSrc;
  logic           busy;

  modport master (
    output req, lock, data,
    input  gnt, regOut, regValid, wrSrc, busy
  );

  modport slave (
    input  req, lock, data,
    output gnt, regOut, regValid, wrSrc, busy
  );

endinterface

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer,
// wrapping around, as one-hot select plus binary index.
module shared_reg_arbiter_rr_pick
  import shared_reg_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idxWidth(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  sel_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic          found;
  logic [IW-1:0] posIdx;

  always_comb begin
    sel_o  = '0;
    idx_o  = '0;
    found  = 1'b0;
    posIdx = '0;
    for (int k = 0; k < N; k++) begin
      posIdx = IW'((int'(ptr_i) + k) % N);
      if (!found && req_i[posIdx]) begin
        sel_o[posIdx] = 1'b1;
        idx_o         = posIdx;
        found         = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter owning one shared W-bit register; a granted
// requester may hold the grant under LOCK for up to MAX_BURST writes.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int            N         = 4,
  parameter int            W         = 8,
  parameter int            MAX_BURST = 4,
  parameter logic [W-1:0]  RST_VAL   = W'(DEFAULT_RST_VAL)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  shared_reg_arbiter_if.slave bus
);

  localparam int IW = idxWidth(N);

  arb_state_e    state_q;
  logic [N-1:0]  gnt_q;
  logic [IW-1:0] gIdx_q;
  logic [IW-1:0] ptr_q;
  logic [W-1:0]  regOut_q;
  logic          regValid_q;
  logic [IW-1:0] wrSrc_q;
  logic [3:0]    burstCnt_q;

  logic [N-1:0]  pickSel;
  logic [IW-1:0] pickIdx;
  logic          pickAny;

  logic [W-1:0]  grantData_d;
  logic          grantReq_d;
  logic          grantLock_d;
  logic          burstMore_d;
  logic [IW-1:0] ptrNext_d;

  shared_reg_arbiter_rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .sel_o (pickSel),
    .idx_o (pickIdx),
    .any_o (pickAny)
  );

  // The one-hot grant masks out every non-granted requester's REQ, LOCK and DATA.
  always_comb begin
    grantData_d = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_q[i]) grantData_d = grantData_d | bus.data[i*W +: W];
    end
  end

  assign grantReq_d  = |(bus.req & gnt_q);
  assign grantLock_d = |(bus.lock & gnt_q);
  assign burstMore_d = grantLock_d && grantReq_d && (burstCnt_q < 4'(MAX_BURST - 1));
  assign ptrNext_d   = (gIdx_q == IW'(N - 1)) ? '0 : gIdx_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gIdx_q     <= '0;
      ptr_q      <= '0;
      regOut_q   <= RST_VAL;
      regValid_q <= 1'b0;
      wrSrc_q    <= '0;
      burstCnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          regValid_q <= 1'b0;
          if (pickAny) begin
            gnt_q      <= pickSel;
            gIdx_q     <= pickIdx;
            burstCnt_q <= '0;
            state_q    <= GRANT;
          end
        end
        GRANT: begin
          if (grantReq_d) begin
            regOut_q   <= grantData_d;
            wrSrc_q    <= gIdx_q;
            regValid_q <= 1'b1;
          end else begin
            regValid_q <= 1'b0;
          end
          // Pointer moves on every release, abandoned grants included.
          if (burstMore_d) begin
            burstCnt_q <= burstCnt_q + 4'd1;
          end else begin
            gnt_q   <= '0;
            ptr_q   <= ptrNext_d;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.regOut   = regOut_q;
  assign bus.regValid = regValid_q;
  assign bus.wrSrc    = wrSrc_q;
  assign bus.busy     = (state_q == GRANT);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter: reset, round robin, burst cap,
// abandoned grant, reset mid-burst and ignored non-granted inputs.
module tb_shared_reg_arbiter;
  import shared_reg_arbiter_pkg::*;

  localparam int N         = 4;
  localparam int W         = 8;
  localparam int MAX_BURST = 4;

  logic       clk = 1'b0;
  logic       rstN;
  logic [7:0] dataArr [4];
  int         checkCount = 0;
  int         errorCount = 0;

  logic [3:0] expGnt [8];
  logic [7:0] expReg [4];

  shared_reg_arbiter_if #(.N(N), .W(W)) intf();

  shared_reg_arbiter #(
    .N         (N),
    .W         (W),
    .MAX_BURST (MAX_BURST),
    .RST_VAL   (8'h00)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rstN),
    .bus    (intf.slave)
  );

  always #5 clk = ~clk;

  assign intf.data = {dataArr[3], dataArr[2], dataArr[1], dataArr[0]};

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [3:0] req, input logic [3:0] lock);
    rstN      = rst;
    intf.req  = req;
    intf.lock = lock;
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  initial begin
    expGnt = '{4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
    expReg = '{8'h11, 8'h12, 8'h13, 8'h10};
    for (int i = 0; i < 4; i++) dataArr[i] = 8'h10 + 8'(i);

    // Reset held with all requests pending
    applyStimulus(1'b0, 4'b1111, 4'b0000);
    stepClk();
    stepClk();
    checkOutput("rst_gnt", 32'(intf.gnt), 32'h0);
    checkOutput("rst_reg", 32'(intf.regOut), 32'h00);
    checkOutput("rst_busy", 32'(intf.busy), 32'h0);
    checkOutput("rst_valid", 32'(intf.regValid), 32'h0);

    applyStimulus(1'b1, 4'b1111, 4'b0000);
    stepClk();
    checkOutput("first_gnt", 32'(intf.gnt), 32'b0001);
    checkOutput("first_busy", 32'(intf.busy), 32'h1);
    checkOutput("first_valid_lo", 32'(intf.regValid), 32'h0);
    stepClk();
    checkOutput("first_reg", 32'(intf.regOut), 32'h10);
    checkOutput("first_valid", 32'(intf.regValid), 32'h1);
    checkOutput("first_gnt_rel", 32'(intf.gnt), 32'h0);

    // Round robin with one idle cycle between grants
    for (int i = 0; i < 8; i++) begin
      stepClk();
      checkOutput($sformatf("rr_gnt%0d", i), 32'(intf.gnt), 32'(expGnt[i]));
      checkOutput($sformatf("rr_onehot%0d", i), 32'($onehot0(intf.gnt)), 32'h1);
      if (i % 2 == 1) begin
        checkOutput($sformatf("rr_reg%0d", i), 32'(intf.regOut), 32'(expReg[i/2]));
        checkOutput($sformatf("rr_src%0d", i), 32'(intf.wrSrc), 32'((i/2 + 1) % 4));
      end
    end

    // Burst cap: LOCK held on requester 2, data increments each cycle
    applyStimulus(1'b1, 4'b0100, 4'b0100);
    stepClk();
    checkOutput("burst_gnt", 32'(intf.gnt), 32'b0100);
    checkOutput("burst_valid_lo", 32'(intf.regValid), 32'h0);
    dataArr[2] = 8'hA0;
    for (int k = 0; k < 4; k++) begin
      stepClk();
      checkOutput($sformatf("burst_reg%0d", k), 32'(intf.regOut), 32'(8'hA0 + 8'(k)));
      checkOutput($sformatf("burst_valid%0d", k), 32'(intf.regValid), 32'h1);
      checkOutput($sformatf("burst_gnt%0d", k), 32'(intf.gnt), (k < 3) ? 32'b0100 : 32'b0000);
      dataArr[2] = 8'hA0 + 8'(k + 1);
    end
    stepClk();
    checkOutput("burst_regrant", 32'(intf.gnt), 32'b0100);
    checkOutput("burst_idle_valid", 32'(intf.regValid), 32'h0);
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    stepClk();
    checkOutput("burst_drop_gnt", 32'(intf.gnt), 32'h0);
    checkOutput("burst_drop_reg", 32'(intf.regOut), 32'hA3);

    // Abandoned grant to requester 1 advances pointer to 2
    applyStimulus(1'b1, 4'b0010, 4'b0000);
    stepClk();
    checkOutput("abandon_gnt", 32'(intf.gnt), 32'b0010);
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    stepClk();
    checkOutput("abandon_rel", 32'(intf.gnt), 32'h0);
    checkOutput("abandon_valid", 32'(intf.regValid), 32'h0);
    checkOutput("abandon_reg", 32'(intf.regOut), 32'hA3);
    applyStimulus(1'b1, 4'b0011, 4'b0000);
    stepClk();
    checkOutput("abandon_next", 32'(intf.gnt), 32'b0001);
    stepClk();
    checkOutput("abandon_wr", 32'(intf.regOut), 32'h10);
    checkOutput("abandon_src", 32'(intf.wrSrc), 32'h0);

    // Reset in the middle of a locked burst on requester 3
    applyStimulus(1'b1, 4'b1000, 4'b1000);
    stepClk();
    checkOutput("mid_gnt", 32'(intf.gnt), 32'b1000);
    stepClk();
    checkOutput("mid_reg", 32'(intf.regOut), 32'h13);
    checkOutput("mid_hold", 32'(intf.gnt), 32'b1000);
    applyStimulus(1'b0, 4'b1000, 4'b1000);
    stepClk();
    checkOutput("mid_rst_reg", 32'(intf.regOut), 32'h00);
    checkOutput("mid_rst_gnt", 32'(intf.gnt), 32'h0);
    checkOutput("mid_rst_valid", 32'(intf.regValid), 32'h0);
    checkOutput("mid_rst_busy", 32'(intf.busy), 32'h0);
    checkOutput("mid_rst_src", 32'(intf.wrSrc), 32'h0);
    applyStimulus(1'b1, 4'b1111, 4'b0000);
    stepClk();
    checkOutput("mid_ptr0", 32'(intf.gnt), 32'b0001);
    checkOutput("mid_post_valid", 32'(intf.regValid), 32'h0);

    // Non-granted LOCK/REQ toggles are ignored; release follows LOCK[0]
    dataArr[0] = 8'h55;
    applyStimulus(1'b1, 4'b1111, 4'b0011);
    stepClk();
    checkOutput("ign_gnt0", 32'(intf.gnt), 32'b0001);
    checkOutput("ign_reg0", 32'(intf.regOut), 32'h55);
    applyStimulus(1'b1, 4'b1011, 4'b0001);
    stepClk();
    checkOutput("ign_gnt1", 32'(intf.gnt), 32'b0001);
    dataArr[0] = 8'h66;
    applyStimulus(1'b1, 4'b1111, 4'b0010);
    stepClk();
    checkOutput("ign_rel", 32'(intf.gnt), 32'h0);
    checkOutput("ign_reg", 32'(intf.regOut), 32'h66);
    checkOutput("ign_valid", 32'(intf.regValid), 32'h1);
    stepClk();
    checkOutput("ign_next", 32'(intf.gnt), 32'b0010);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
